instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage of the 64-bit core, directly downstream of program_counter/branch_unit.
- Owns the speculative fetch PC and issues sequential word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions, with their PCs, in a small queue and hands them to decode over a valid/ready interface.
- Accepts branch redirects from branch_unit: flushes buffered and in-flight fetches, then restarts at the target.

Parameters:
- DEPTH, 4, instruction queue entries (power of 2, ≥2)
- MAX_OUT, 2, max outstanding imem requests (power of 2, ≥1)
- RESET_PC, 64'h0, fetch address after reset
- PC_INC, 4, byte increment per sequential fetch

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- redirect  in  1  branch taken, pulse, from branch_unit
- redirect_pc  in  64  branch target (pc_branch)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  64  word address requested
- imem_rsp_valid  in  1  response valid, in request order, never stalled
- imem_rsp_data  in  32  instruction word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts
- out_instr  out  32  instruction
- out_pc  out  64  PC of out_instr
- flush_busy  out  1  high while stale responses are still being dropped

Behaviour:
- Reset (rst=0 at an edge):
  - fetch_pc=RESET_PC; queue, outstanding count and drop count all cleared.
  - All outputs 0: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, flush_busy=0.
  - Applies mid-operation. Responses arriving in the reset cycle are discarded. Responses for pre-reset requests that arrive after reset are the memory's responsibility; the memory shares the same reset.
- Issue rule:
  - imem_req_valid = !redirect && drop_cnt==0 && outstanding<MAX_OUT && (q_count+outstanding)<DEPTH.
  - imem_req_addr=fetch_pc.
  - On handshake: the address is pushed to a MAX_OUT-deep pending-PC queue, outstanding+1, fetch_pc += PC_INC. fetch_pc wraps modulo 2^64.
- Response: on imem_rsp_valid with drop_cnt==0, pop the pending-PC queue, write {pc, data} to the instruction queue, outstanding−1.
  - The issue rule guarantees no overflow; an assertion flags imem_rsp_valid with outstanding==0.
- Latency: request accepted at cycle N, response at N+k (k≥1). out_valid rises at N+k+1 because the queue write is registered.
- Output: out_valid = q_count≠0; out_instr/out_pc show the head entry. Pop on out_valid&&out_ready.
  - Head stays stable while out_ready=0.
  - Push and pop in the same cycle leave q_count unchanged.
- Redirect (priority over everything else in that cycle):
  - fetch_pc ← {redirect_pc[63:2],2'b00}.
  - Instruction queue and pending-PC queue emptied.
  - drop_cnt ← outstanding − (imem_rsp_valid ? 1 : 0); outstanding ← drop_cnt.
  - A response arriving in the redirect cycle is discarded.
  - No request is issued in the redirect cycle. out_valid is 0 from the next cycle.
- Dropping: while drop_cnt≠0, each imem_rsp_valid decrements drop_cnt and outstanding, and is not written.
  - flush_busy = drop_cnt≠0.
  - Issue resumes the cycle after drop_cnt reaches 0.
- Back-to-back redirects: each redirect recomputes drop_cnt from the current outstanding; the last target wins.
- Queue full with out_ready=0: issue stalls via the q_count+outstanding term; no entry is ever lost.

Decomposition:
- fetch_pkg holds: INSTR_W=32, XLEN=64, PC_INC, RESET_PC default, and typedef fetch_entry_t {pc[63:0], instr[31:0]}.
- One sub-module, sync_fifo, parameterized by width and depth, with push/pop/flush/count. Instantiated twice: instruction queue (96-bit) and pending-PC queue (64-bit).

Test Plan:
- Reset: hold rst=0 for 3 cycles with imem_rsp_valid toggling → all outputs 0. After release, first request has imem_req_addr=0.
- Streaming: 1-cycle memory, always ready, out_ready=1 → out_pc 0,4,8,12… one per cycle, first out_valid 2 cycles after the first request; out_instr matches the memory image.
- Backpressure: out_ready=0 → exactly DEPTH=4 requests issued, then imem_req_valid=0. out_pc=0 held stable. Release → 4 pops, then fetching resumes at 0x10.
- Forward redirect: 2 requests in flight, redirect_pc=1000 → 2 stale responses dropped, flush_busy high 2 cycles; next out_pc=0x3E8, then 0x3EC.
- Backward redirect with same-cycle response: from 0x3F0, redirect_pc=0x3E8−100=0x384 while imem_rsp_valid=1 → that response discarded, drop_cnt=1, next out_pc=0x384. Also unaligned redirect_pc=0x386 → fetch at 0x384.
- Wrap/mid-reset: RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 → out_pc …FFF8, …FFFC, 0x0. Asserting rst with 2 outstanding → queue empty next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN / INSTR_W      : address and instruction widths
//   DEFAULT_PC_INC      : byte step between sequential fetches
//   DEFAULT_RESET_PC    : fetch address after reset
//   fetch_entry_t       : one buffered instruction together with its PC
package fetch_pkg;

    localparam int XLEN    = 64;
    localparam int INSTR_W = 32;

    localparam int               DEFAULT_PC_INC   = 4;
    localparam logic [XLEN-1:0]  DEFAULT_RESET_PC = 64'h0;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_checker.sv
// Protocol checks for instr_fetch_unit.
//   imem_rsp_valid : response strobe from instruction memory
//   outstanding    : requests accepted but not yet answered
//   pend_count     : entries in the pending-PC queue
//   drop_cnt       : stale responses still to be discarded
module instr_fetch_unit_checker #(
    parameter int OUT_W = 2
) (
    input logic             clk,
    input logic             rst,
    input logic             imem_rsp_valid,
    input logic [OUT_W-1:0] outstanding,
    input logic [OUT_W-1:0] pend_count,
    input logic [OUT_W-1:0] drop_cnt
);

    // Memory must never answer a request that was not issued.
    a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> (outstanding != OUT_W'(0)));

    // Outside a flush every outstanding request has a PC waiting for it.
    a_pend_matches: assert property (@(posedge clk) disable iff (!rst)
        (drop_cnt == OUT_W'(0)) |-> (pend_count == outstanding));

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a single-cycle flush.
//   clk, rst      : clock and synchronous active-low reset
//   flush         : empties the FIFO; wins over push and pop in the same cycle
//   push/push_data: write one entry (caller guarantees room)
//   pop/pop_data  : pop_data always shows the head; pop removes it
//   count         : current number of entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap explicitly so a single-entry FIFO also works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(DEPTH - 1)) begin
            r = {PTR_W{1'b0}};
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // Next pointer and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset because count gates their use.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the speculative fetch PC, issues sequential word
// requests to instruction memory, buffers responses with their PCs and
// hands them to decode. A branch redirect flushes everything buffered and
// discards responses for requests already in flight.
//   clk, rst                 : clock, synchronous active-low reset
//   redirect, redirect_pc    : taken-branch pulse and target
//   imem_req_*               : request channel (valid/ready, address)
//   imem_rsp_valid/_data     : in-order response channel, never stalled
//   out_valid/ready/instr/pc : instruction handoff to decode
//   flush_busy               : stale responses are still being dropped
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 2,
    parameter logic [XLEN-1:0]  RESET_PC = fetch_pkg::DEFAULT_RESET_PC,
    parameter int               PC_INC   = fetch_pkg::DEFAULT_PC_INC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect,
    input  logic [XLEN-1:0]     redirect_pc,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [XLEN-1:0]     imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [INSTR_W-1:0]  imem_rsp_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [INSTR_W-1:0]  out_instr,
    output logic [XLEN-1:0]     out_pc,
    output logic                flush_busy
);

    localparam int IQ_CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W    = $clog2(MAX_OUT + 1);
    localparam int SUM_W    = ((IQ_CNT_W > OUT_W) ? IQ_CNT_W : OUT_W) + 1;

    logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic [OUT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [IQ_CNT_W-1:0] iq_count;
    logic [OUT_W-1:0]    pq_count;
    fetch_entry_t        iq_head;
    fetch_entry_t        iq_push_entry;
    logic [XLEN-1:0]     pq_head;
    logic [SUM_W-1:0]    in_use;
    logic                req_fire;
    logic                iq_push;
    logic                iq_pop;
    logic                pq_pop;
    logic                q_flush;

    // Slots already claimed: buffered entries plus responses still owed.
    assign in_use = SUM_W'(iq_count) + SUM_W'(outstanding_q);

    // Issue only when a response is guaranteed a free queue slot.
    assign imem_req_valid = rst && !redirect
                         && (drop_cnt_q == OUT_W'(0))
                         && (outstanding_q < OUT_W'(MAX_OUT))
                         && (in_use < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid  = (iq_count != IQ_CNT_W'(0));
    assign out_instr  = out_valid ? iq_head.instr : {INSTR_W{1'b0}};
    assign out_pc     = out_valid ? iq_head.pc    : {XLEN{1'b0}};
    assign iq_pop     = out_valid && out_ready;
    assign flush_busy = (drop_cnt_q != OUT_W'(0));

    assign iq_push_entry = '{pc: pq_head, instr: imem_rsp_data};

    // Next fetch PC, outstanding/drop bookkeeping and queue controls.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        iq_push       = 1'b0;
        pq_pop        = 1'b0;
        q_flush       = 1'b0;
        if (redirect) begin
            // Every in-flight request except one answered this cycle
            // becomes stale; that same-cycle response is discarded.
            fetch_pc_d    = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
            q_flush       = 1'b1;
            drop_cnt_d    = outstanding_q - OUT_W'(imem_rsp_valid);
            outstanding_d = outstanding_q - OUT_W'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(PC_INC);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (imem_rsp_valid) begin
                if (drop_cnt_q != OUT_W'(0)) begin
                    drop_cnt_d = drop_cnt_q - OUT_W'(1);
                end else begin
                    pq_pop  = 1'b1;
                    iq_push = 1'b1;
                end
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            outstanding_d = outstanding_q + OUT_W'(req_fire) - OUT_W'(imem_rsp_valid);
        end
    end

    // Fetch PC and in-flight counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= {OUT_W{1'b0}};
            drop_cnt_q    <= {OUT_W{1'b0}};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (iq_push),
        .push_data (iq_push_entry),
        .pop       (iq_pop),
        .pop_data  (iq_head),
        .count     (iq_count)
    );

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (MAX_OUT)
    ) u_pend_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (pq_pop),
        .pop_data  (pq_head),
        .count     (pq_count)
    );

    instr_fetch_unit_checker #(
        .OUT_W (OUT_W)
    ) u_checker (
        .clk            (clk),
        .rst            (rst),
        .imem_rsp_valid (imem_rsp_valid),
        .outstanding    (outstanding_q),
        .pend_count     (pq_count),
        .drop_cnt       (drop_cnt_q)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: an in-order memory model with
// configurable latency feeds the DUT; expected {pc, instr} pairs are
// queued when a scenario starts and compared as decode pops them.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        flush_busy;

    logic        w_req_valid, w_out_valid, w_flush_busy;
    logic [63:0] w_req_addr, w_out_pc;
    logic [31:0] w_out_instr;

    int n_checks = 0;
    int n_errors = 0;
    int lat = 1;
    int cyc = 0;
    int n_accept = 0;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t sb[$];

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .flush_busy(flush_busy)
    );

    instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8)) dut_w (
        .clk(clk), .rst(rst), .redirect(1'b0), .redirect_pc(64'h0),
        .imem_req_valid(w_req_valid), .imem_req_ready(1'b0),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(1'b0),
        .imem_rsp_data(32'h0), .out_valid(w_out_valid), .out_ready(1'b0),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .flush_busy(w_flush_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {~a[17:2], a[17:2]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Memory model: latches handshakes seen before the edge, answers in order.
    always begin : memory_model
        logic        acc, rsp_now, rst_s;
        logic [63:0] acc_addr;
        @(negedge clk);
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp_now  = imem_rsp_valid;
        rst_s    = rst;
        @(posedge clk);
        cyc++;
        if (!rst_s) begin
            pend.delete();
        end else begin
            if (rsp_now && pend.size() > 0) void'(pend.pop_front());
            if (acc) begin
                pend.push_back('{addr: acc_addr, due: cyc + lat - 1});
                n_accept++;
            end
        end
        #2;
        if (!rst) begin
            imem_rsp_valid = cyc[0];
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    // Scoreboard: compare each decode pop against the next expected entry.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && sb.size() > 0) begin
            fetch_entry_t e;
            e = sb.pop_front();
            check_eq("out_pc", out_pc, e.pc);
            check_eq("out_instr", {32'h0, out_instr}, {32'h0, e.instr});
        end
    end

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1 rst = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic push_exp(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] p;
            p = start + 64'(i * 4);
            sb.push_back('{pc: p, instr: mem_word(p)});
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            wait_neg();
            n++;
        end
        check_eq({tag, "_drain"}, 64'(sb.size()), 64'h0);
        sb.delete();
    endtask

    task automatic redirect_to(input logic [63:0] pc);
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = pc;
        @(posedge clk); #1 redirect = 1'b0;
    endtask

    initial begin
        int base, n;
        bit found;

        // Reset held for three edges while responses toggle.
        repeat (3) @(posedge clk);
        wait_neg();
        check_eq("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check_eq("rst_req_addr", imem_req_addr, 64'h0);
        check_eq("rst_out_valid", 64'(out_valid), 64'h0);
        check_eq("rst_out_instr", 64'(out_instr), 64'h0);
        check_eq("rst_out_pc", out_pc, 64'h0);
        check_eq("rst_flush_busy", 64'(flush_busy), 64'h0);

        // Streaming with a 1-cycle memory.
        push_exp(64'h0, 12);
        @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
        wait_neg();
        check_eq("first_req_valid", 64'(imem_req_valid), 64'h1);
        check_eq("first_req_addr", imem_req_addr, 64'h0);
        check_eq("w_req_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        check_eq("w_req_valid", 64'(w_req_valid), 64'h1);
        check_eq("w_idle", {w_out_pc[31:0], w_out_instr}, 64'h0);
        check_eq("w_flags", {62'h0, w_out_valid, w_flush_busy}, 64'h0);
        wait_neg();
        check_eq("lat_n1", 64'(out_valid), 64'h0);
        wait_neg();
        check_eq("lat_n2", 64'(out_valid), 64'h1);
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            wait_neg();
            n++;
        end
        check_eq("stream_rate", 64'(n), 64'd11);

        // Backpressure: decode stalled, exactly DEPTH requests.
        @(posedge clk); #1 out_ready = 1'b0;
        do_reset(1);
        base = n_accept;
        repeat (12) wait_neg();
        check_eq("bp_count", 64'(n_accept - base), 64'd4);
        check_eq("bp_stall", 64'(imem_req_valid), 64'h0);
        check_eq("bp_hold_pc", out_pc, 64'h0);
        check_eq("bp_hold_instr", 64'(out_instr), 64'(mem_word(64'h0)));
        push_exp(64'h0, 6);
        @(posedge clk); #1 out_ready = 1'b1;
        drain("bp");

        // Forward redirect with two requests in flight.
        @(posedge clk); #1 out_ready = 1'b0; lat = 3;
        do_reset(1);
        @(posedge clk); #1;
        @(posedge clk); #1 redirect = 1'b1; redirect_pc = 64'd1000;
        wait_neg();
        check_eq("fwd_noreq", 64'(imem_req_valid), 64'h0);
        @(posedge clk); #1 redirect = 1'b0;
        wait_neg();
        check_eq("fwd_busy1", 64'(flush_busy), 64'h1);
        check_eq("fwd_empty", 64'(out_valid), 64'h0);
        wait_neg();
        check_eq("fwd_busy2", 64'(flush_busy), 64'h1);
        wait_neg();
        check_eq("fwd_busy_end", 64'(flush_busy), 64'h0);
        check_eq("fwd_req_addr", imem_req_addr, 64'h3E8);
        push_exp(64'h3E8, 3);
        @(posedge clk); #1 out_ready = 1'b1;
        drain("fwd");

        // Backward redirect coinciding with a response.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #3;
            found = imem_rsp_valid && !imem_req_valid && !flush_busy;
        end
        check_eq("bwd_found", 64'(found), 64'h1);
        redirect = 1'b1; redirect_pc = 64'h384; out_ready = 1'b0;
        @(posedge clk); #1 redirect = 1'b0;
        wait_neg();
        check_eq("bwd_busy", 64'(flush_busy), 64'h1);
        check_eq("bwd_empty", 64'(out_valid), 64'h0);
        push_exp(64'h384, 3);
        @(posedge clk); #1 out_ready = 1'b1;
        drain("bwd");

        // Unaligned target is word-aligned.
        redirect_to(64'h386);
        push_exp(64'h384, 3);
        out_ready = 1'b1;
        drain("unal");

        // Fetch PC wraps through zero.
        redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
        push_exp(64'hFFFF_FFFF_FFFF_FFF8, 4);
        out_ready = 1'b1;
        drain("wrap");

        // Mid-operation reset with requests outstanding and entries queued.
        @(posedge clk); #1 out_ready = 1'b0;
        do_reset(1);
        repeat (5) @(posedge clk);
        wait_neg();
        check_eq("mid_pre_valid", 64'(out_valid), 64'h1);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        wait_neg();
        check_eq("mid_out_valid", 64'(out_valid), 64'h0);
        check_eq("mid_req_valid", 64'(imem_req_valid), 64'h0);
        check_eq("mid_req_addr", imem_req_addr, 64'h0);
        check_eq("mid_flush_busy", 64'(flush_busy), 64'h0);
        push_exp(64'h0, 3);
        @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
        drain("mid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
